// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type, region decode and abort data for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IO_WAIT = 2'd1,
    IO_DONE = 2'd2
  } dmem_state_e;

  // Sliced down to the data width by the user; returned on an aborted peripheral read.
  localparam logic [63:0] ABORT_DATA = '1;

  // The top address bit selects the peripheral region.
  function automatic logic io_region(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] sh;
    sh = addr >> (aw - 1);
    return sh[0];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU data port plus slow peripheral port seen by the responder
interface dmem_responder_if #(
  parameter int width       = 16,
  parameter int daddr_width = 8
);
  logic [daddr_width-1:0] daddr;
  logic                   dwrite;
  logic                   dread;
  logic [width-1:0]       dD;
  logic [width-1:0]       dQ;
  logic                   wait_state;

  logic [daddr_width-2:0] io_addr;
  logic [width-1:0]       io_wdata;
  logic                   io_we;
  logic                   io_re;
  logic                   io_req;
  logic                   io_ack;
  logic [width-1:0]       io_rdata;
  logic                   io_timeout;

  // master: the CPU and the peripheral together; slave: the responder between them
  modport master (
    output daddr, dwrite, dread, dD, io_ack, io_rdata,
    input  dQ, wait_state, io_addr, io_wdata, io_we, io_re, io_req, io_timeout
  );

  modport slave (
    input  daddr, dwrite, dread, dD, io_ack, io_rdata,
    output dQ, wait_state, io_addr, io_wdata, io_we, io_re, io_req, io_timeout
  );
endinterface

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port synchronous RAM, read-before-write, registered read
module dmem_ram #(
  parameter int width = 16,
  parameter int aw    = 7
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [aw-1:0]    addr_i,
  input  logic [width-1:0] wdata_i,
  output logic [width-1:0] rdata_o
);

  logic [width-1:0] mem_q [2**aw];
  logic [width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - CPU data responder: zero-wait RAM in the low half, stalled req/ack peripheral in the high half
// Optional IO-wait abort enabled by defining DMEM_IO_TIMEOUT_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int width       = 16,
  parameter int daddr_width = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int RAM_AW = daddr_width - 1;

  dmem_state_e       state_q, state_d;
  logic              io_req_q, io_req_d;
  logic              io_we_q, io_we_d;
  logic              io_re_q, io_re_d;
  logic [RAM_AW-1:0] io_addr_q, io_addr_d;
  logic [width-1:0]  io_wdata_q, io_wdata_d;
  logic [width-1:0]  io_dq_q, io_dq_d;
  logic              ram_sel_q, ram_sel_d;
  logic              wait_state;

  logic              access;
  logic              io_hit;
  logic              ram_en;
  logic [width-1:0]  ram_rdata;

  assign access = bus.dread | bus.dwrite;
  assign io_hit = io_region(32'(bus.daddr), daddr_width);
  assign ram_en = (state_q == IDLE) && access && !io_hit && !reset;

  dmem_ram #(
    .width (width),
    .aw    (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_en & bus.dwrite),
    .re_i    (ram_en & bus.dread),
    .addr_i  (bus.daddr[RAM_AW-1:0]),
    .wdata_i (bus.dD),
    .rdata_o (ram_rdata)
  );

`ifdef DMEM_IO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    io_req_d   = io_req_q;
    io_we_d    = io_we_q;
    io_re_d    = io_re_q;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    io_dq_d    = io_dq_q;
    ram_sel_d  = ram_sel_q;
    wait_state = 1'b0;
`ifdef DMEM_IO_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (access && io_hit) begin
          wait_state = 1'b1;
          io_addr_d  = bus.daddr[RAM_AW-1:0];
          io_wdata_d = bus.dD;
          io_we_d    = bus.dwrite;
          io_re_d    = bus.dread & ~bus.dwrite;
          io_req_d   = 1'b1;
          state_d    = IO_WAIT;
`ifdef DMEM_IO_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end else if (ram_en && bus.dread) begin
          ram_sel_d = 1'b1;
        end
      end
      IO_WAIT: begin
        wait_state = 1'b1;
        if (bus.io_ack) begin
          io_req_d = 1'b0;
          if (io_re_q) begin
            io_dq_d   = bus.io_rdata;
            ram_sel_d = 1'b0;
          end
          state_d = IO_DONE;
`ifdef DMEM_IO_TIMEOUT_EN
        // An ack arriving on the expiry cycle is handled above and takes priority.
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          io_req_d = 1'b0;
          if (io_re_q) begin
            io_dq_d   = ABORT_DATA[width-1:0];
            ram_sel_d = 1'b0;
          end
          tmo_d   = 1'b1;
          state_d = IO_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      IO_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_re_q    <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
      io_dq_q    <= '0;
      ram_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      io_req_q   <= io_req_d;
      io_we_q    <= io_we_d;
      io_re_q    <= io_re_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      io_dq_q    <= io_dq_d;
      ram_sel_q  <= ram_sel_d;
    end
  end

`ifdef DMEM_IO_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.io_timeout = tmo_q;
`else
  assign bus.io_timeout = 1'b0;
`endif

  // dQ is either the RAM read register or the peripheral capture, whichever completed last.
  assign bus.dQ         = ram_sel_q ? ram_rdata : io_dq_q;
  assign bus.wait_state = wait_state;
  assign bus.io_req     = io_req_q;
  assign bus.io_we      = io_we_q;
  assign bus.io_re      = io_re_q;
  assign bus.io_addr    = io_addr_q;
  assign bus.io_wdata   = io_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (RAM, IO handshake, reset, optional timeout)
module tb_dmem_responder;

  localparam int W   = 16;
  localparam int AW  = 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_responder_if #(.width(W), .daddr_width(AW)) bus ();

  dmem_responder #(
    .width       (W),
    .daddr_width (AW),
    .TIMEOUT     (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int           n_vec  = 0;
  int           n_miss = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] dq_model;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_bus();
    bus.daddr    = '0;
    bus.dread    = 1'b0;
    bus.dwrite   = 1'b0;
    bus.dD       = '0;
    bus.io_ack   = 1'b0;
    bus.io_rdata = '0;
  endtask

  task automatic sb_pop(input string tag);
    logic [W-1:0] e;
    check({tag, "_sb"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, bus.dQ, e);
    end
  endtask

  task automatic ram_access(input logic [7:0] a, input logic rd, input logic wr,
                            input logic [W-1:0] d, input logic [W-1:0] e, input string tag);
    if (rd) begin
      exp_q.push_back(e);
      dq_model = e;
    end
    bus.daddr  = a;
    bus.dread  = rd;
    bus.dwrite = wr;
    bus.dD     = d;
    #1;
    check({tag, "_ws"}, bus.wait_state, 0);
    tick();
    bus.dread  = 1'b0;
    bus.dwrite = 1'b0;
    if (rd) sb_pop(tag);
  endtask

  task automatic io_access(input logic [7:0] a, input logic rd, input logic wr,
                           input logic [W-1:0] wd, input int ack_at, input logic [W-1:0] rdat,
                           input logic [W-1:0] exp_d, input int exp_ws, input int exp_req,
                           input string tag);
    int ws_n = 0;
    int req_n = 0;
    bit done = 1'b0;
    exp_q.push_back(exp_d);
    dq_model   = exp_d;
    bus.daddr  = a;
    bus.dread  = rd;
    bus.dwrite = wr;
    bus.dD     = wd;
    #1;
    if (bus.wait_state) ws_n++;
    tick();
    check({tag, "_addr"}, bus.io_addr, a[6:0]);
    check({tag, "_we"}, bus.io_we, wr);
    check({tag, "_re"}, bus.io_re, rd & ~wr);
    check({tag, "_wdata"}, bus.io_wdata, wd);
    for (int k = 1; k <= 300; k++) begin
      if (k == ack_at) begin
        bus.io_ack   = 1'b1;
        bus.io_rdata = rdat;
      end
      #1;
      if (!bus.wait_state) begin
        done = 1'b1;
        break;
      end
      ws_n++;
      if (bus.io_req) req_n++;
      tick();
      bus.io_ack   = 1'b0;
      bus.io_rdata = '0;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_wscyc"}, ws_n, exp_ws);
    check({tag, "_reqcyc"}, req_n, exp_req);
    check({tag, "_reqdrop"}, bus.io_req, 0);
    sb_pop(tag);
    idle_bus();
    tick();
    check({tag, "_hold"}, bus.dQ, dq_model);
  endtask

  logic [7:0]   rnd_a [4] = '{8'h00, 8'h7F, 8'h3C, 8'h41};
  logic [W-1:0] rnd_d [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    idle_bus();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    dq_model = '0;
    check("rst_dq", bus.dQ, 0);
    check("rst_ws", bus.wait_state, 0);
    check("rst_req", bus.io_req, 0);
    check("rst_we", bus.io_we, 0);
    check("rst_re", bus.io_re, 0);
    check("rst_addr", bus.io_addr, 0);
    check("rst_wdata", bus.io_wdata, 0);
    check("rst_tmo", bus.io_timeout, 0);

    ram_access(8'h05, 1'b0, 1'b1, 16'h1234, '0, "ram_wr05");
    ram_access(8'h05, 1'b1, 1'b0, '0, 16'h1234, "ram_rd05");

    io_access(8'h83, 1'b1, 1'b0, '0, 3, 16'hBEEF, 16'hBEEF, 4, 3, "io_rd83");
    io_access(8'h80, 1'b0, 1'b1, 16'h00AA, 1, '0, dq_model, 2, 1, "io_wr80");
    io_access(8'h85, 1'b0, 1'b1, 16'hDEAD, 2, '0, dq_model, 3, 2, "io_wr85");
    ram_access(8'h05, 1'b1, 1'b0, '0, 16'h1234, "ram_rd05b");

    ram_access(8'h10, 1'b0, 1'b1, 16'h0001, '0, "ram_wr10");
    ram_access(8'h10, 1'b1, 1'b1, 16'h0002, 16'h0001, "ram_rw10");
    ram_access(8'h10, 1'b1, 1'b0, '0, 16'h0002, "ram_rd10");

    for (int i = 0; i < 4; i++) begin
      rnd_d[i] = W'($urandom);
      ram_access(rnd_a[i], 1'b0, 1'b1, rnd_d[i], '0, "ram_wr_tab");
    end
    for (int i = 0; i < 4; i++) begin
      ram_access(rnd_a[i], 1'b1, 1'b0, '0, rnd_d[i], "ram_rd_tab");
    end

    // Reset lands in the second IO_WAIT cycle of a pending read.
    bus.daddr = 8'h90;
    bus.dread = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_bus();
    #1;
    dq_model = '0;
    check("rstio_req", bus.io_req, 0);
    check("rstio_ws", bus.wait_state, 0);
    check("rstio_dq", bus.dQ, 0);
    check("rstio_re", bus.io_re, 0);
    check("rstio_addr", bus.io_addr, 0);
    bus.io_ack   = 1'b1;
    bus.io_rdata = 16'h5555;
    tick();
    idle_bus();
    #1;
    check("stray_dq", bus.dQ, 0);
    check("stray_req", bus.io_req, 0);
    check("stray_ws", bus.wait_state, 0);
    ram_access(8'h05, 1'b1, 1'b0, '0, 16'h1234, "ram_keep05");

`ifdef DMEM_IO_TIMEOUT_EN
    io_access(8'h84, 1'b1, 1'b0, '0, TMO, 16'h1357, 16'h1357, TMO + 1, TMO, "io_race");
    check("race_tmo", bus.io_timeout, 0);
    io_access(8'h86, 1'b1, 1'b0, '0, 0, '0, 16'hFFFF, TMO + 1, TMO, "io_tmo");
    check("tmo_flag", bus.io_timeout, 1);
    tick();
    check("tmo_sticky", bus.io_timeout, 1);
    io_access(8'h87, 1'b1, 1'b0, '0, 2, 16'h2468, 16'h2468, 3, 2, "io_after_tmo");
    check("tmo_sticky2", bus.io_timeout, 1);
`else
    bus.daddr = 8'h86;
    bus.dread = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    #1;
    check("hang_ws", bus.wait_state, 1);
    check("hang_req", bus.io_req, 1);
    check("hang_tmo", bus.io_timeout, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_bus();
    #1;
    check("hang_rst_ws", bus.wait_state, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
